// File: rtl/ts_scan_sched.sv
// ts_scan_sched -- scan scheduler for the timestamp datapath.
//
// Owns one shared scan timer. Each scan lasts SCAN_LEN clk cycles (timer
// 0 .. SCAN_LEN-1) and is marked by a one-cycle sync_out pulse in its first
// cycle. During the scan, the first rising edge on each channel is stamped
// with the current timer value. After the scan, one record per channel
// (channel id, timestamp, hit flag) is streamed out over valid/ready. If
// enable is still high at the end of the drain, the next scan starts
// immediately.
//
// Optional feature (compile-time macro TS_SKIP_EMPTY_EN):
//   defined     : the drain emits only channels that saw a hit, in ascending
//                 order. A scan without hits spends one idle drain cycle.
//   not defined : the drain always emits NCH records, including hit = 0
//                 records with timestamp 0.
//
// Ports:
//   clk          clock
//   reset_n      synchronous, active-low reset
//   enable       run request, sampled in IDLE and at the end of the drain
//   sig_in       NCH signal inputs, already synchronised to clk
//   sync_out     one-cycle pulse in the first scan cycle (timer = 0)
//   scan_active  high while scanning
//   out_valid    record valid
//   out_ready    downstream accept
//   out_ch       record channel index
//   out_time     captured timestamp (0 if no hit)
//   out_hit      channel saw a rising edge during the scan
//   overrun      one-cycle pulse: a rising edge arrived during the drain
//                and was dropped
module ts_scan_sched #(
   parameter int              NCH      = 4,
   parameter int              TW       = 32,
   parameter longint unsigned SCAN_LEN = 64'd1000
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    enable,
   input  logic [NCH-1:0]          sig_in,
   output logic                    sync_out,
   output logic                    scan_active,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [$clog2(NCH)-1:0]  out_ch,
   output logic [TW-1:0]           out_time,
   output logic                    out_hit,
   output logic                    overrun
);

   localparam int            CW        = $clog2(NCH);
   localparam logic [TW-1:0] LAST_TICK = TW'(SCAN_LEN - 64'd1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Lowest set bit of mask at or above index start.
   // Result: {found, index}; index is 0 when nothing is found.
   function automatic logic [CW:0] seek_hit(input logic [NCH-1:0] mask,
                                            input int             start);
      logic [CW:0] res;
      res = {(CW+1){1'b0}};
      for (int i = NCH-1; i >= 0; i--) begin
         if ((i >= start) && mask[i]) begin
            res = {1'b1, CW'(i)};
         end
      end
      return res;
   endfunction

   state_t          state_r, state_nxt;
   logic [TW-1:0]   timer_r, timer_nxt;
   logic [NCH-1:0]  sig_prev_r;
   logic [NCH-1:0]  hit_r, hit_nxt;
   logic [TW-1:0]   ts_r   [NCH];
   logic [TW-1:0]   ts_nxt [NCH];

   logic            sync_r, sync_nxt;
   logic            active_r, active_nxt;
   logic            valid_r, valid_nxt;
   logic [CW-1:0]   ch_r, ch_nxt;
   logic [TW-1:0]   time_r, time_nxt;
   logic            hit_out_r, hit_out_nxt;
   logic            ovr_r, ovr_nxt;

   logic [NCH-1:0]  rise_s;
   logic [NCH-1:0]  hit_cap_s;
   logic [TW-1:0]   ts_cap_s [NCH];
   logic [NCH-1:0]  mask_s;
   logic [CW:0]     sel_s;
   logic            start_s;
   logic            done_s;

   // The drain walks every channel, or only those that saw a hit. In the
   // drain hit_cap_s equals hit_r, so one mask serves entry and advance.
`ifdef TS_SKIP_EMPTY_EN
   assign mask_s = hit_cap_s;
`else
   assign mask_s = {NCH{1'b1}};
`endif

   // Edge detect and first-edge capture. The captured view is used both
   // as the next stored value and to load the first record on the last
   // scan cycle, so a hit in that cycle is visible in its record.
   always_comb begin
      rise_s    = sig_in & ~sig_prev_r;
      hit_cap_s = hit_r;
      ts_cap_s  = ts_r;
      for (int i = 0; i < NCH; i++) begin
         if ((state_r == ST_SCAN) && rise_s[i] && !hit_r[i]) begin
            hit_cap_s[i] = 1'b1;
            ts_cap_s[i]  = timer_r;
         end else begin
            hit_cap_s[i] = hit_r[i];
            ts_cap_s[i]  = ts_r[i];
         end
      end
   end

   // Next-state and next-output logic of the scan/drain sequencer.
   always_comb begin
      state_nxt   = state_r;
      timer_nxt   = timer_r;
      hit_nxt     = hit_cap_s;
      ts_nxt      = ts_cap_s;
      sync_nxt    = 1'b0;
      active_nxt  = active_r;
      valid_nxt   = valid_r;
      ch_nxt      = ch_r;
      time_nxt    = time_r;
      hit_out_nxt = hit_out_r;
      ovr_nxt     = 1'b0;
      sel_s       = {(CW+1){1'b0}};
      start_s     = 1'b0;
      done_s      = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if (enable) begin
               start_s = 1'b1;
            end else begin
               start_s = 1'b0;
            end
         end

         ST_SCAN: begin
            if (timer_r == LAST_TICK) begin
               // Timer parks at zero so it never passes SCAN_LEN-1.
               sel_s       = seek_hit(mask_s, 0);
               state_nxt   = ST_DRAIN;
               active_nxt  = 1'b0;
               timer_nxt   = {TW{1'b0}};
               valid_nxt   = sel_s[CW];
               ch_nxt      = sel_s[CW-1:0];
               time_nxt    = ts_cap_s[sel_s[CW-1:0]];
               hit_out_nxt = hit_cap_s[sel_s[CW-1:0]];
            end else begin
               timer_nxt = timer_r + TW'(1);
            end
         end

         ST_DRAIN: begin
            // Edges here cannot be captured; flag them.
            ovr_nxt = |rise_s;
            if (!valid_r) begin
               // Empty drain: nothing to emit this scan.
               done_s = 1'b1;
            end else if (out_ready) begin
               sel_s = seek_hit(mask_s, int'(ch_r) + 1);
               if (sel_s[CW]) begin
                  ch_nxt      = sel_s[CW-1:0];
                  time_nxt    = ts_r[sel_s[CW-1:0]];
                  hit_out_nxt = hit_r[sel_s[CW-1:0]];
               end else begin
                  valid_nxt = 1'b0;
                  done_s    = 1'b1;
               end
            end else begin
               // Stalled: record registers hold.
               valid_nxt = valid_r;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      if (done_s) begin
         if (enable) begin
            start_s = 1'b1;
         end else begin
            state_nxt = ST_IDLE;
         end
      end else begin
         done_s = 1'b0;
      end

      // Scan start: clearing stored timestamps keeps no-hit records at 0.
      if (start_s) begin
         state_nxt  = ST_SCAN;
         sync_nxt   = 1'b1;
         active_nxt = 1'b1;
         timer_nxt  = {TW{1'b0}};
         hit_nxt    = {NCH{1'b0}};
         for (int i = 0; i < NCH; i++) begin
            ts_nxt[i] = {TW{1'b0}};
         end
      end else begin
         start_s = 1'b0;
      end
   end

   // State, capture and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r    <= ST_IDLE;
         timer_r    <= {TW{1'b0}};
         sig_prev_r <= {NCH{1'b0}};
         hit_r      <= {NCH{1'b0}};
         for (int i = 0; i < NCH; i++) begin
            ts_r[i] <= {TW{1'b0}};
         end
         sync_r     <= 1'b0;
         active_r   <= 1'b0;
         valid_r    <= 1'b0;
         ch_r       <= {CW{1'b0}};
         time_r     <= {TW{1'b0}};
         hit_out_r  <= 1'b0;
         ovr_r      <= 1'b0;
      end else begin
         state_r    <= state_nxt;
         timer_r    <= timer_nxt;
         sig_prev_r <= sig_in;
         hit_r      <= hit_nxt;
         for (int i = 0; i < NCH; i++) begin
            ts_r[i] <= ts_nxt[i];
         end
         sync_r     <= sync_nxt;
         active_r   <= active_nxt;
         valid_r    <= valid_nxt;
         ch_r       <= ch_nxt;
         time_r     <= time_nxt;
         hit_out_r  <= hit_out_nxt;
         ovr_r      <= ovr_nxt;
      end
   end

   assign sync_out    = sync_r;
   assign scan_active = active_r;
   assign out_valid   = valid_r;
   assign out_ch      = ch_r;
   assign out_time    = time_r;
   assign out_hit     = hit_out_r;
   assign overrun     = ovr_r;

endmodule

// File: tb/tb_ts_scan_sched.sv
// tb_ts_scan_sched -- self-checking bench for ts_scan_sched (NCH=4, TW=16,
// SCAN_LEN=16). A queue-based scan model predicts every output on every
// cycle; directed scenarios add literal checks on records, sync spacing,
// stalls, overrun, enable drop and reset mid-drain. Honours TS_SKIP_EMPTY_EN.
module tb_ts_scan_sched;

   localparam int NCH      = 4;
   localparam int TW       = 16;
   localparam int SCAN_LEN = 16;
`ifdef TS_SKIP_EMPTY_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   typedef struct packed {
      logic [1:0]  ch;
      logic [15:0] t;
      logic        h;
   } rec_t;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            enable;
   logic [NCH-1:0]  sig_in;
   logic            sync_out, scan_active, out_valid, out_ready, out_hit, overrun;
   logic [1:0]      out_ch;
   logic [TW-1:0]   out_time;

   int errors = 0;
   int checks = 0;
   int cyc_cnt = 0;
   int sync_cnt = 0;
   int ovr_cnt = 0;
   bit chk_en = 1'b0;
   rec_t rec_log[$];

   // model state
   int             m_phase = 0;   // 0 idle, 1 scan, 2 drain
   int             m_t = 0;
   int             m_first[NCH];
   logic [NCH-1:0] m_prev = '0;
   logic [NCH-1:0] m_rise;
   rec_t           m_q[$];
   bit             m_empty = 1'b0;
   bit             m_go, m_done;
   bit             e_sync = 1'b0, e_active = 1'b0, e_ovr = 1'b0, e_valid;

   ts_scan_sched #(.NCH(NCH), .TW(TW), .SCAN_LEN(SCAN_LEN)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .sig_in(sig_in),
      .sync_out(sync_out), .scan_active(scan_active), .out_valid(out_valid),
      .out_ready(out_ready), .out_ch(out_ch), .out_time(out_time),
      .out_hit(out_hit), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_sync();
      bit got;
      got = 1'b0;
      for (int k = 0; k < 200 && !got; k++) begin
         @(posedge clk);
         #2;
         got = sync_out;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL wait_sync: no sync_out within 200 cycles");
      end
   endtask

   task automatic chk_rec(input int i, input int ch, input int t, input int h);
      logic [31:0] act;
      logic [31:0] exp;
      act = 32'hFFFF_FFFF;
      if (i < rec_log.size()) begin
         act = {13'd0, rec_log[i].ch, rec_log[i].t, rec_log[i].h};
      end
      exp = {13'd0, 2'(ch), 16'(t), 1'(h)};
      check($sformatf("rec%0d", i), act, exp);
   endtask

   // Scan model: recomputes expected outputs after each rising edge.
   initial begin : model
      forever begin
         @(posedge clk);
         cyc_cnt = cyc_cnt + 1;
         e_sync = 1'b0;
         e_ovr  = 1'b0;
         m_go   = 1'b0;
         m_done = 1'b0;
         if (!reset_n) begin
            m_phase = 0;
            m_t = 0;
            m_prev = '0;
            m_q.delete();
            m_empty = 1'b0;
            e_active = 1'b0;
            for (int i = 0; i < NCH; i++) m_first[i] = -1;
         end else begin
            m_rise = sig_in & ~m_prev;
            m_prev = sig_in;
            if (m_phase == 0) begin
               m_go = enable;
            end else if (m_phase == 1) begin
               for (int i = 0; i < NCH; i++)
                  if (m_rise[i] && m_first[i] < 0) m_first[i] = m_t;
               if (m_t == SCAN_LEN - 1) begin
                  for (int i = 0; i < NCH; i++) begin
                     if (!SKIP || m_first[i] >= 0) begin
                        rec_t r;
                        r.ch = 2'(i);
                        r.t  = (m_first[i] >= 0) ? 16'(m_first[i]) : 16'd0;
                        r.h  = (m_first[i] >= 0);
                        m_q.push_back(r);
                     end
                  end
                  m_phase = 2;
                  m_empty = (m_q.size() == 0);
                  e_active = 1'b0;
               end else begin
                  m_t++;
               end
            end else begin
               if (m_rise != '0) e_ovr = 1'b1;
               if (m_empty) begin
                  m_empty = 1'b0;
                  m_done = 1'b1;
               end else if (out_ready) begin
                  void'(m_q.pop_front());
                  if (m_q.size() == 0) m_done = 1'b1;
               end
            end
            if (m_done) begin
               if (enable) m_go = 1'b1;
               else m_phase = 0;
            end
            if (m_go) begin
               m_phase = 1;
               m_t = 0;
               for (int i = 0; i < NCH; i++) m_first[i] = -1;
               e_sync = 1'b1;
               e_active = 1'b1;
            end
         end
      end
   end

   // Compare process: DUT versus model on every falling edge, plus logging.
   initial begin : compare
      forever begin
         @(negedge clk);
         if (chk_en) begin
            e_valid = (m_phase == 2) && (m_q.size() > 0);
            check("sync_out", 32'(sync_out), 32'(e_sync));
            check("scan_active", 32'(scan_active), 32'(e_active));
            check("out_valid", 32'(out_valid), 32'(e_valid));
            check("overrun", 32'(overrun), 32'(e_ovr));
            if (e_valid) begin
               check("out_ch", 32'(out_ch), 32'(m_q[0].ch));
               check("out_time", 32'(out_time), 32'(m_q[0].t));
               check("out_hit", 32'(out_hit), 32'(m_q[0].h));
            end
            if (sync_out) sync_cnt++;
            if (overrun) ovr_cnt++;
            if (out_valid && out_ready) begin
               rec_t r;
               r.ch = out_ch;
               r.t  = out_time;
               r.h  = out_hit;
               rec_log.push_back(r);
            end
         end
      end
   end

   initial begin : stim
      int t_en, t_a, t_b, n_sync, ovr0;
      reset_n = 1'b0; enable = 1'b0; sig_in = '0; out_ready = 1'b1;
      cyc(1);
      chk_en = 1'b1;
      cyc(2);
      check("rst_sync", 32'(sync_out), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_rec", {13'd0, out_ch, out_time, out_hit}, 32'd0);
      check("rst_act_ovr", {30'd0, scan_active, overrun}, 32'd0);
      reset_n = 1'b1;
      cyc(2);

      // Scan A: no edges
      enable = 1'b1;
      t_en = cyc_cnt;
      wait_sync();
      t_a = cyc_cnt;
      check("sync_latency", 32'(t_a - t_en), 32'd1);
      check("active_in_scan", 32'(scan_active), 32'd1);
      rec_log.delete();

      // Scan B: ch1 @3, ch1 again @9 (ignored), ch2 @15
      wait_sync();
      t_b = cyc_cnt;
      if (SKIP) begin
         check("nrec_A", 32'(rec_log.size()), 32'd0);
         check("period_A", 32'(t_b - t_a), 32'd17);
      end else begin
         check("nrec_A", 32'(rec_log.size()), 32'd4);
         for (int i = 0; i < NCH; i++) chk_rec(i, i, 0, 0);
         check("period_A", 32'(t_b - t_a), 32'd20);
      end
      rec_log.delete();
      cyc(3);  sig_in = 4'b0010;
      cyc(1);  sig_in = 4'b0000;
      cyc(5);  sig_in = 4'b0010;
      cyc(1);  sig_in = 4'b0000;
      cyc(5);  sig_in = 4'b0100;
      cyc(1);  sig_in = 4'b0000;

      // Scan C: ch0 and ch3 together @7, then a stall on record ch2
      wait_sync();
      if (SKIP) begin
         check("nrec_B", 32'(rec_log.size()), 32'd2);
         chk_rec(0, 1, 3, 1);
         chk_rec(1, 2, 15, 1);
      end else begin
         check("nrec_B", 32'(rec_log.size()), 32'd4);
         chk_rec(0, 0, 0, 0);
         chk_rec(1, 1, 3, 1);
         chk_rec(2, 2, 15, 1);
         chk_rec(3, 3, 0, 0);
      end
      rec_log.delete();
      cyc(7);  sig_in = 4'b1001;
      cyc(1);  sig_in = 4'b0000;
`ifndef TS_SKIP_EMPTY_EN
      cyc(8);                 // first drain cycle
      cyc(2);                 // record ch2 on the bus
      out_ready = 1'b0;
      ovr0 = ovr_cnt;
      cyc(2);  sig_in = 4'b0001;
      cyc(1);  sig_in = 4'b0000;
      cyc(2);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_ch", 32'(out_ch), 32'd2);
      check("stall_time", 32'(out_time), 32'd0);
      check("stall_overrun", 32'(ovr_cnt - ovr0), 32'd1);
      out_ready = 1'b1;
`endif

      // Scan D: ch0 @4 unaffected by the overrun; enable dropped @6
      wait_sync();
      if (SKIP) begin
         check("nrec_C", 32'(rec_log.size()), 32'd2);
         chk_rec(0, 0, 7, 1);
         chk_rec(1, 3, 7, 1);
      end else begin
         check("nrec_C", 32'(rec_log.size()), 32'd4);
         chk_rec(0, 0, 7, 1);
         chk_rec(1, 1, 0, 0);
         chk_rec(2, 2, 0, 0);
         chk_rec(3, 3, 7, 1);
      end
      rec_log.delete();
      cyc(4);  sig_in = 4'b0001;
      cyc(1);  sig_in = 4'b0000;
      cyc(1);  enable = 1'b0;
      n_sync = sync_cnt;
      cyc(40);
      check("no_sync_after_drop", 32'(sync_cnt - n_sync), 32'd0);
      check("idle_active", 32'(scan_active), 32'd0);
      if (SKIP) begin
         check("nrec_D", 32'(rec_log.size()), 32'd1);
         chk_rec(0, 0, 4, 1);
      end else begin
         check("nrec_D", 32'(rec_log.size()), 32'd4);
         chk_rec(0, 0, 4, 1);
         chk_rec(1, 1, 0, 0);
         chk_rec(2, 2, 0, 0);
         chk_rec(3, 3, 0, 0);
      end

      // Scan E: reset in the middle of the drain
      enable = 1'b1;
      wait_sync();
      cyc(2);  sig_in = 4'b1010;
      cyc(1);  sig_in = 4'b0000;
      cyc(14);
      check("pre_reset_valid", 32'(out_valid), 32'd1);
      reset_n = 1'b0;
      enable = 1'b0;
      cyc(1);
      check("post_reset_valid", 32'(out_valid), 32'd0);
      check("post_reset_rec", {13'd0, out_ch, out_time, out_hit}, 32'd0);
      check("post_reset_active", {30'd0, scan_active, sync_out}, 32'd0);
      reset_n = 1'b1;
      cyc(3);

`ifdef TS_SKIP_EMPTY_EN
      // Skip-empty: single hit ch2 @5, then a zero-hit scan
      enable = 1'b1;
      wait_sync();
      rec_log.delete();
      cyc(5);  sig_in = 4'b0100;
      cyc(1);  sig_in = 4'b0000;
      wait_sync();
      t_a = cyc_cnt;
      check("nrec_F", 32'(rec_log.size()), 32'd1);
      chk_rec(0, 2, 5, 1);
      rec_log.delete();
      wait_sync();
      t_b = cyc_cnt;
      enable = 1'b0;
      check("nrec_G", 32'(rec_log.size()), 32'd0);
      check("period_empty", 32'(t_b - t_a), 32'd17);
      cyc(30);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ts_scan_sched.md
# ts_scan_sched

Scan scheduler for the timestamp datapath. It owns the scan timer, issues the per-scan sync pulse, and captures the first rising edge on each of NCH signal inputs during a fixed-length scan window. At the end of each scan it streams one record per channel (channel id, timestamp, hit flag) over a valid/ready interface to the downstream packetiser. It replaces the per-channel free-running timestamp counters with one shared, sequenced timer.

## Interface
Parameters:
- NCH, 4: number of signal channels (≥2).
- TW, 32: timer/timestamp width.
- SCAN_LEN, 1000: scan window length in clk cycles; 2 ≤ SCAN_LEN ≤ 2^TW.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset: synchronous, active-low.
- enable  in  1  run request; sampled in IDLE and at end of DRAIN.
- sig_in  in  NCH  signal inputs, already synchronised to clk.
- sync_out  out  1  one-cycle pulse marking scan start (timer = 0).
- scan_active  out  1  high during SCAN.
- out_valid  out  1  record valid.
- out_ready  in  1  downstream accept.
- out_ch  out  $clog2(NCH)  record channel index.
- out_time  out  TW  captured timestamp (0 if no hit).
- out_hit  out  1  channel saw a rising edge this scan.
- overrun  out  1  one-cycle pulse: rising edge dropped during DRAIN.

## Operation
- Reset values: state IDLE; sync_out, scan_active, out_valid, out_hit, and overrun = 0; out_ch = 0; out_time = 0; timer = 0; hit[] = 0; time[] = 0; sig_prev = 0.
- Edge detect: rise[i] = sig_in[i] & ~sig_prev[i]. sig_prev <= sig_in every non-reset cycle, in all states.
- IDLE: if enable = 1, next cycle enters SCAN with sync_out = 1, timer = 0, hit[] cleared.
- SCAN: scan_active = 1. timer increments by 1 per cycle.
  - rise[i] with hit[i] = 0: time[i] <= timer, hit[i] <= 1.
  - Later edges on that channel in the same scan are ignored (not overrun).
  - In the cycle with timer == SCAN_LEN-1, edges are still captured. The next state is DRAIN with idx = 0.
- DRAIN: out_valid = 1, out_ch = idx, out_time = time[idx], out_hit = hit[idx].
  - On out_valid & out_ready, idx advances.
  - On the handshake for idx = NCH-1:
    - enable = 1: next cycle is SCAN, with sync_out = 1, timer = 0, and hit[] cleared. There is no IDLE gap.
    - enable = 0: next state is IDLE.
  - Any rise[] during DRAIN is not captured; overrun pulses for one cycle per such cycle.
- enable deasserted during SCAN or DRAIN: the current scan completes and fully drains, then the block goes to IDLE.
- Simultaneous edges on several channels: all captured with the same timestamp.
- Timer never wraps: the scan terminates at SCAN_LEN-1 ≤ 2^TW-1.
- Reset mid-scan or mid-drain: all state returns to reset values on the next edge; pending records are discarded.

## Timing
- sync_out, scan_active, and all out_* signals are registered outputs.
- Capture latency: edge sampled at cycle c is stored with timestamp timer(c). sig_in high in the first SCAN cycle (sig_prev = 0) records time 0.
- out_ch, out_time, and out_hit are held stable while out_valid & !out_ready.
- One record per cycle when out_ready is held high.
- Scan period with out_ready = 1 and enable = 1: SCAN_LEN + NCH cycles between sync_out pulses.
- First sync_out appears one cycle after enable is sampled high in IDLE.

## Configuration
- TS_SKIP_EMPTY_EN defined:
  - DRAIN emits records only for channels with hit = 1, in ascending index order; out_hit is always 1.
  - A scan with zero hits spends exactly one DRAIN cycle with out_valid = 0, then proceeds by the enable rule.
  - Period becomes SCAN_LEN + max(1, hits).
- Not defined: DRAIN always emits exactly NCH records, including hit = 0 records with out_time = 0.

## Test plan
- Reset, enable = 1, NCH = 4, SCAN_LEN = 16, no edges, out_ready = 1:
  - sync_out high in cycle 1 after enable.
  - 4 records: ch 0..3, hit = 0, time = 0.
  - Next sync_out exactly 20 cycles after the first.
- Rising edges on ch1 at timer 3 and ch2 at timer 15 (last cycle):
  - records ch1 time 3 hit 1, ch2 time 15 hit 1.
  - A second ch1 edge at timer 9 is ignored.
- ch0 and ch3 rise in the same cycle at timer 7 -> both records carry time 7.
- out_ready low for 5 cycles on record ch2:
  - out_valid held high, with out_ch = 2 and out_time unchanged.
  - An edge on ch0 during the stall -> one overrun pulse; the next scan's ch0 is unaffected.
- enable dropped mid-SCAN:
  - scan finishes and all 4 records are drained.
  - Then IDLE, with no further sync_out.
  - reset_n low mid-DRAIN -> out_valid = 0 next cycle.
- TS_SKIP_EMPTY_EN defined, only ch2 hit at timer 5 -> exactly one record (ch2, time 5).
  - A following zero-hit scan has no records, and sync_out period = SCAN_LEN + 1.
